checker_hm: RTL and testbench

- Host-memory read engine directly downstream of the checker read-mode FSM.
- On hm_start it fetches one 64-bit word at hm_addr over a split-transaction read bus: one tagged request, then two 32-bit completions (low dword first).
- Reports hm_end, hm_error or hm_timeout, and returns the assembled word on hm_data.

---
 rtl/checker_hm_pkg.sv | 15 +
 rtl/checker_hm_timer.sv | 37 +++
 rtl/checker_hm.sv | 196 +++++++++++++++++++
 tb/tb_checker_hm.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/checker_hm_pkg.sv
// Shared encodings for the checker host-memory read engine: FSM states and
// completion status codes.
package checker_hm_pkg;

  typedef enum logic [1:0] {
    CHECKER_HM_STATE_IDLE    = 2'd0,
    CHECKER_HM_STATE_REQ     = 2'd1,
    CHECKER_HM_STATE_WAIT_LO = 2'd2,
    CHECKER_HM_STATE_WAIT_HI = 2'd3
  } hm_state_e;

  localparam logic [2:0] CHECKER_HM_CPL_SC  = 3'd0;
  localparam logic [2:0] CHECKER_HM_CPL_CRS = 3'd2;

endpackage

// File: rtl/checker_hm_timer.sv
// Loadable down-counter used as the completion timeout; saturates at zero.
// Only the system reset clears it, a soft abort leaves it alone.
module checker_hm_timer #(
  parameter int TO_W = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            load,
  input  logic [TO_W-1:0] load_val,
  input  logic            en,
  output logic [TO_W-1:0] cnt,
  output logic            expired
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TO_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign expired = (cnt_q == '0);

endmodule

// File: rtl/checker_hm.sv
// Host-memory read engine: one tagged request, two dword completions, sticky
// end/error/timeout status. CRS re-issue is enabled with CHECKER_HM_RETRY_EN.
module checker_hm
  import checker_hm_pkg::*;
#(
  parameter int TIMEOUT   = 1024,
  parameter int TO_W      = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        hm_rst,
  input  logic        hm_start,
  input  logic [63:0] hm_addr,
  output logic        hm_end,
  output logic        hm_error,
  output logic        hm_timeout,
  output logic [63:0] hm_data,
  output logic        rd_req,
  input  logic        rd_ack,
  output logic [63:0] rd_addr,
  output logic [4:0]  rd_tag,
  input  logic        rd_cpl_valid,
  input  logic [4:0]  rd_cpl_tag,
  input  logic [2:0]  rd_cpl_status,
  input  logic [31:0] rd_cpl_data
);

  if ((TIMEOUT >= (1 << TO_W)) || (TIMEOUT < 0) || (MAX_RETRY < 0)) begin : g_bad_param
    $error("checker_hm: TIMEOUT must fit in TO_W bits and MAX_RETRY must be >= 0");
  end

  hm_state_e   state_q, state_d;
  logic        req_q, req_d;
  logic [63:0] addr_q, addr_d;
  logic [4:0]  tag_q, tag_d;
  logic [63:0] data_q, data_d;
  logic        end_q, end_d;
  logic        error_q, error_d;
  logic        timeout_q, timeout_d;

`ifdef CHECKER_HM_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q, retry_d;
`endif

  logic            timer_load, timer_en, timer_expired;
  logic [TO_W-1:0] timer_cnt;
  logic            beat_hit, tmo_hit;

  checker_hm_timer #(.TO_W(TO_W)) u_timer (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .load     (timer_load),
    .load_val (TO_W'(TIMEOUT)),
    .en       (timer_en),
    .cnt      (timer_cnt),
    .expired  (timer_expired)
  );

  assign beat_hit = rd_cpl_valid && (rd_cpl_tag == tag_q);
  // Fire on the cycle the count steps to zero so the window is exactly TIMEOUT cycles.
  assign tmo_hit  = timer_expired || (timer_cnt == TO_W'(1));

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    tag_d      = tag_q;
    data_d     = data_q;
    end_d      = end_q;
    error_d    = error_q;
    timeout_d  = timeout_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
`ifdef CHECKER_HM_RETRY_EN
    retry_d    = retry_q;
`endif

    if (hm_rst) begin
      state_d   = CHECKER_HM_STATE_IDLE;
      req_d     = 1'b0;
      data_d    = '0;
      end_d     = 1'b0;
      error_d   = 1'b0;
      timeout_d = 1'b0;
`ifdef CHECKER_HM_RETRY_EN
      retry_d   = '0;
`endif
      if (state_q != CHECKER_HM_STATE_IDLE) tag_d = tag_q + 5'd1;
    end else begin
      case (state_q)
        CHECKER_HM_STATE_IDLE: begin
          if (hm_start) begin
            end_d     = 1'b0;
            timeout_d = 1'b0;
`ifdef CHECKER_HM_RETRY_EN
            retry_d   = '0;
`endif
            if (hm_addr[2:0] != 3'd0) begin
              error_d = 1'b1;
            end else begin
              error_d = 1'b0;
              addr_d  = hm_addr;
              req_d   = 1'b1;
              state_d = CHECKER_HM_STATE_REQ;
            end
          end
        end

        CHECKER_HM_STATE_REQ: begin
          if (rd_ack) begin
            req_d      = 1'b0;
            timer_load = 1'b1;
            state_d    = CHECKER_HM_STATE_WAIT_LO;
          end
        end

        CHECKER_HM_STATE_WAIT_LO,
        CHECKER_HM_STATE_WAIT_HI: begin
          timer_en = 1'b1;
          if (beat_hit) begin
            if (rd_cpl_status == CHECKER_HM_CPL_SC) begin
              if (state_q == CHECKER_HM_STATE_WAIT_LO) begin
                data_d[31:0] = rd_cpl_data;
                state_d      = CHECKER_HM_STATE_WAIT_HI;
              end else begin
                data_d[63:32] = rd_cpl_data;
                end_d         = 1'b1;
                tag_d         = tag_q + 5'd1;
                state_d       = CHECKER_HM_STATE_IDLE;
              end
            end
`ifdef CHECKER_HM_RETRY_EN
            else if ((rd_cpl_status == CHECKER_HM_CPL_CRS) &&
                     (retry_q < RW'(MAX_RETRY))) begin
              retry_d = retry_q + RW'(1);
              tag_d   = tag_q + 5'd1;
              req_d   = 1'b1;
              state_d = CHECKER_HM_STATE_REQ;
            end
`endif
            else begin
              error_d = 1'b1;
              tag_d   = tag_q + 5'd1;
              state_d = CHECKER_HM_STATE_IDLE;
            end
          end else if (tmo_hit) begin
            timeout_d = 1'b1;
            tag_d     = tag_q + 5'd1;
            state_d   = CHECKER_HM_STATE_IDLE;
          end
        end

        default: state_d = CHECKER_HM_STATE_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= CHECKER_HM_STATE_IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      tag_q     <= '0;
      data_q    <= '0;
      end_q     <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef CHECKER_HM_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      end_q     <= end_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
`ifdef CHECKER_HM_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign hm_end     = end_q;
  assign hm_error   = error_q;
  assign hm_timeout = timeout_q;
  assign hm_data    = data_q;
  assign rd_req     = req_q;
  assign rd_addr    = addr_q;
  assign rd_tag     = tag_q;

endmodule

// File: tb/tb_checker_hm.sv
// Directed bench for checker_hm with TIMEOUT=16; retry scenarios are built
// only when CHECKER_HM_RETRY_EN is defined.
module tb_checker_hm;

  logic        sys_clk;
  logic        sys_rst;
  logic        hm_rst;
  logic        hm_start;
  logic [63:0] hm_addr;
  logic        hm_end;
  logic        hm_error;
  logic        hm_timeout;
  logic [63:0] hm_data;
  logic        rd_req;
  logic        rd_ack;
  logic [63:0] rd_addr;
  logic [4:0]  rd_tag;
  logic        rd_cpl_valid;
  logic [4:0]  rd_cpl_tag;
  logic [2:0]  rd_cpl_status;
  logic [31:0] rd_cpl_data;

  int n_vec = 0;
  int n_err = 0;

  checker_hm #(.TIMEOUT(16), .TO_W(16), .MAX_RETRY(3)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .hm_rst        (hm_rst),
    .hm_start      (hm_start),
    .hm_addr       (hm_addr),
    .hm_end        (hm_end),
    .hm_error      (hm_error),
    .hm_timeout    (hm_timeout),
    .hm_data       (hm_data),
    .rd_req        (rd_req),
    .rd_ack        (rd_ack),
    .rd_addr       (rd_addr),
    .rd_tag        (rd_tag),
    .rd_cpl_valid  (rd_cpl_valid),
    .rd_cpl_tag    (rd_cpl_tag),
    .rd_cpl_status (rd_cpl_status),
    .rd_cpl_data   (rd_cpl_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic start_rd(input logic [63:0] addr);
    hm_start = 1'b1;
    hm_addr  = addr;
    tick();
    hm_start = 1'b0;
  endtask

  task automatic ack_rd();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  task automatic beat(input logic [4:0] tag, input logic [2:0] st, input logic [31:0] d);
    rd_cpl_valid  = 1'b1;
    rd_cpl_tag    = tag;
    rd_cpl_status = st;
    rd_cpl_data   = d;
    tick();
    rd_cpl_valid  = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    #12;
    n_vec++; if (hm_end !== 1'b0) begin n_err++; $display("FAIL reset_end got %b exp 0", hm_end); end
    n_vec++; if (hm_error !== 1'b0) begin n_err++; $display("FAIL reset_error got %b exp 0", hm_error); end
    n_vec++; if (hm_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b exp 0", hm_timeout); end
    n_vec++; if (hm_data !== 64'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", hm_data); end
    n_vec++; if (rd_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b exp 0", rd_req); end
    n_vec++; if (rd_tag !== 5'd0) begin n_err++; $display("FAIL reset_tag got %0d exp 0", rd_tag); end
    n_vec++; if (rd_addr !== 64'h0) begin n_err++; $display("FAIL reset_addr got %h exp 0", rd_addr); end
    #10;
    sys_rst = 1'b1;
  endtask

  task automatic test_normal();
    hm_rst = 1'b1;
    tick();
    hm_rst = 1'b0;
    start_rd(64'h1000);
    n_vec++; if (rd_req !== 1'b1) begin n_err++; $display("FAIL norm_req got %b exp 1", rd_req); end
    n_vec++; if (rd_addr !== 64'h1000) begin n_err++; $display("FAIL norm_addr got %h exp 1000", rd_addr); end
    n_vec++; if (rd_tag !== 5'd0) begin n_err++; $display("FAIL norm_tag got %0d exp 0", rd_tag); end
    tick();
    n_vec++; if (rd_req !== 1'b1) begin n_err++; $display("FAIL norm_req_hold got %b exp 1", rd_req); end
    ack_rd();
    n_vec++; if (rd_req !== 1'b0) begin n_err++; $display("FAIL norm_req_drop got %b exp 0", rd_req); end
    beat(5'd0, 3'd0, 32'hDEADBEEF);
    n_vec++; if (hm_end !== 1'b0) begin n_err++; $display("FAIL norm_end_early got %b exp 0", hm_end); end
    beat(5'd0, 3'd0, 32'h01234567);
    n_vec++; if (hm_end !== 1'b1) begin n_err++; $display("FAIL norm_end got %b exp 1", hm_end); end
    n_vec++; if (hm_data !== 64'h01234567DEADBEEF) begin n_err++; $display("FAIL norm_data got %h exp 01234567deadbeef", hm_data); end
    n_vec++; if (rd_tag !== 5'd1) begin n_err++; $display("FAIL norm_next_tag got %0d exp 1", rd_tag); end
    n_vec++; if ({hm_error, hm_timeout} !== 2'b00) begin n_err++; $display("FAIL norm_flags got %b exp 00", {hm_error, hm_timeout}); end
  endtask

  task automatic test_misaligned();
    start_rd(64'h1004);
    n_vec++; if (hm_error !== 1'b1) begin n_err++; $display("FAIL mis_error got %b exp 1", hm_error); end
    n_vec++; if (hm_end !== 1'b0) begin n_err++; $display("FAIL mis_end_clr got %b exp 0", hm_end); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (rd_req !== 1'b0) begin n_err++; $display("FAIL mis_req c%0d got %b exp 0", i, rd_req); end
      tick();
    end
    n_vec++; if (rd_tag !== 5'd1) begin n_err++; $display("FAIL mis_tag got %0d exp 1", rd_tag); end
  endtask

  task automatic test_fault();
    start_rd(64'h2000);
    n_vec++; if (hm_error !== 1'b0) begin n_err++; $display("FAIL fault_err_clr got %b exp 0", hm_error); end
    ack_rd();
    beat(5'd1, 3'd4, 32'hCAFEF00D);
    n_vec++; if (hm_error !== 1'b1) begin n_err++; $display("FAIL fault_error got %b exp 1", hm_error); end
    n_vec++; if (hm_end !== 1'b0) begin n_err++; $display("FAIL fault_end got %b exp 0", hm_end); end
    n_vec++; if (hm_data[63:32] !== 32'h01234567) begin n_err++; $display("FAIL fault_data_hi got %h exp 01234567", hm_data[63:32]); end
    n_vec++; if (rd_tag !== 5'd2) begin n_err++; $display("FAIL fault_tag got %0d exp 2", rd_tag); end
    n_vec++; if (rd_req !== 1'b0) begin n_err++; $display("FAIL fault_req got %b exp 0", rd_req); end
  endtask

  task automatic test_timeout();
    start_rd(64'h3000);
    n_vec++; if (rd_tag !== 5'd2) begin n_err++; $display("FAIL to_tag got %0d exp 2", rd_tag); end
    ack_rd();
    for (int i = 1; i < 16; i++) begin
      tick();
      n_vec++; if (hm_timeout !== 1'b0) begin n_err++; $display("FAIL to_early c%0d got %b exp 0", i, hm_timeout); end
    end
    tick();
    n_vec++; if (hm_timeout !== 1'b1) begin n_err++; $display("FAIL to_fire got %b exp 1", hm_timeout); end
    n_vec++; if (hm_end !== 1'b0) begin n_err++; $display("FAIL to_end got %b exp 0", hm_end); end
    n_vec++; if (rd_tag !== 5'd3) begin n_err++; $display("FAIL to_tag_inc got %0d exp 3", rd_tag); end
    beat(5'd2, 3'd0, 32'hBADBAD00);
    n_vec++; if ({hm_end, hm_error, hm_timeout} !== 3'b001) begin n_err++; $display("FAIL to_late_beat got %b exp 001", {hm_end, hm_error, hm_timeout}); end
    start_rd(64'h4000);
    n_vec++; if (rd_tag !== 5'd3) begin n_err++; $display("FAIL to_rd2_tag got %0d exp 3", rd_tag); end
    n_vec++; if (hm_timeout !== 1'b0) begin n_err++; $display("FAIL to_rd2_clr got %b exp 0", hm_timeout); end
    ack_rd();
    beat(5'd2, 3'd0, 32'hBADBAD01);
    beat(5'd3, 3'd0, 32'h11111111);
    beat(5'd2, 3'd4, 32'hBADBAD02);
    beat(5'd3, 3'd0, 32'h22222222);
    n_vec++; if (hm_end !== 1'b1) begin n_err++; $display("FAIL to_rd2_end got %b exp 1", hm_end); end
    n_vec++; if (hm_data !== 64'h2222222211111111) begin n_err++; $display("FAIL to_rd2_data got %h exp 2222222211111111", hm_data); end
    n_vec++; if (rd_tag !== 5'd4) begin n_err++; $display("FAIL to_rd2_tag_inc got %0d exp 4", rd_tag); end
  endtask

  task automatic test_expiry_race();
    start_rd(64'h5000);
    ack_rd();
    beat(5'd4, 3'd0, 32'hAAAA5555);
    for (int i = 2; i < 16; i++) tick();
    n_vec++; if ({hm_end, hm_timeout} !== 2'b00) begin n_err++; $display("FAIL race_pre got %b exp 00", {hm_end, hm_timeout}); end
    beat(5'd4, 3'd0, 32'h5555AAAA);
    n_vec++; if (hm_end !== 1'b1) begin n_err++; $display("FAIL race_end got %b exp 1", hm_end); end
    n_vec++; if (hm_timeout !== 1'b0) begin n_err++; $display("FAIL race_timeout got %b exp 0", hm_timeout); end
    n_vec++; if (hm_data !== 64'h5555AAAAAAAA5555) begin n_err++; $display("FAIL race_data got %h exp 5555aaaaaaaa5555", hm_data); end
  endtask

  task automatic test_abort();
    start_rd(64'h6000);
    ack_rd();
    beat(5'd5, 3'd0, 32'h0F0F0F0F);
    hm_rst = 1'b1;
    tick();
    hm_rst = 1'b0;
    n_vec++; if ({hm_end, hm_error, hm_timeout} !== 3'b000) begin n_err++; $display("FAIL abort_flags got %b exp 000", {hm_end, hm_error, hm_timeout}); end
    n_vec++; if (rd_req !== 1'b0) begin n_err++; $display("FAIL abort_req got %b exp 0", rd_req); end
    n_vec++; if (hm_data !== 64'h0) begin n_err++; $display("FAIL abort_data got %h exp 0", hm_data); end
    n_vec++; if (rd_tag !== 5'd6) begin n_err++; $display("FAIL abort_tag got %0d exp 6", rd_tag); end
    beat(5'd5, 3'd0, 32'hF0F0F0F0);
    n_vec++; if ({hm_end, hm_error, hm_timeout} !== 3'b000) begin n_err++; $display("FAIL abort_stale got %b exp 000", {hm_end, hm_error, hm_timeout}); end
    start_rd(64'h6008);
    start_rd(64'h9000);
    n_vec++; if (rd_addr !== 64'h6008) begin n_err++; $display("FAIL busy_start_addr got %h exp 6008", rd_addr); end
    n_vec++; if (rd_req !== 1'b1) begin n_err++; $display("FAIL busy_start_req got %b exp 1", rd_req); end
    hm_rst = 1'b1;
    tick();
    hm_rst = 1'b0;
    n_vec++; if (rd_req !== 1'b0) begin n_err++; $display("FAIL abort_req2 got %b exp 0", rd_req); end
    n_vec++; if (rd_tag !== 5'd7) begin n_err++; $display("FAIL abort_req_tag got %0d exp 7", rd_tag); end
  endtask

`ifdef CHECKER_HM_RETRY_EN
  task automatic test_retry();
    logic [4:0] t;
    t = 5'd7;
    start_rd(64'h7000);
    for (int r = 0; r < 3; r++) begin
      ack_rd();
      beat(t, 3'd2, 32'h0);
      t = t + 5'd1;
      n_vec++; if (rd_req !== 1'b1) begin n_err++; $display("FAIL retry_req r%0d got %b exp 1", r, rd_req); end
      n_vec++; if (rd_tag !== t) begin n_err++; $display("FAIL retry_tag r%0d got %0d exp %0d", r, rd_tag, t); end
    end
    ack_rd();
    beat(t, 3'd0, 32'h33333333);
    beat(t, 3'd0, 32'h44444444);
    n_vec++; if ({hm_end, hm_error} !== 2'b10) begin n_err++; $display("FAIL retry_ok got %b exp 10", {hm_end, hm_error}); end
    n_vec++; if (hm_data !== 64'h4444444433333333) begin n_err++; $display("FAIL retry_data got %h exp 4444444433333333", hm_data); end
    t = t + 5'd1;
    start_rd(64'h7100);
    for (int r = 0; r < 4; r++) begin
      ack_rd();
      beat(t, 3'd2, 32'h0);
      t = t + 5'd1;
    end
    n_vec++; if (hm_error !== 1'b1) begin n_err++; $display("FAIL retry_exhaust got %b exp 1", hm_error); end
    n_vec++; if (rd_req !== 1'b0) begin n_err++; $display("FAIL retry_exhaust_req got %b exp 0", rd_req); end
    n_vec++; if (rd_tag !== 5'd15) begin n_err++; $display("FAIL retry_exhaust_tag got %0d exp 15", rd_tag); end
  endtask
`else
  task automatic test_crs();
    start_rd(64'h7000);
    ack_rd();
    beat(5'd7, 3'd2, 32'h0);
    n_vec++; if (hm_error !== 1'b1) begin n_err++; $display("FAIL crs_error got %b exp 1", hm_error); end
    n_vec++; if (rd_req !== 1'b0) begin n_err++; $display("FAIL crs_req got %b exp 0", rd_req); end
    n_vec++; if (rd_tag !== 5'd8) begin n_err++; $display("FAIL crs_tag got %0d exp 8", rd_tag); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    hm_rst        = 1'b0;
    hm_start      = 1'b0;
    hm_addr       = '0;
    rd_ack        = 1'b0;
    rd_cpl_valid  = 1'b0;
    rd_cpl_tag    = '0;
    rd_cpl_status = '0;
    rd_cpl_data   = '0;
    test_reset();
    test_normal();
    test_misaligned();
    test_fault();
    test_timeout();
    test_expiry_race();
    test_abort();
`ifdef CHECKER_HM_RETRY_EN
    test_retry();
`else
    test_crs();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
